// File: rtl/alu_seq.sv
// alu_seq: 65xx-family ALU with single-cycle classic ops and barrel shifter,
// plus iterative unsigned multiply/divide behind a start/busy/done handshake.
module alu_seq #(
  parameter int unsigned dw  = 16,
  parameter int unsigned SHW = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           RDY,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [3:0]     op,
  input  logic           right,
  input  logic           rotate,
  input  logic [dw-1:0]  AI,
  input  logic [dw-1:0]  BI,
  input  logic           CI,
  input  logic [SHW-1:0] EI,
  output logic           busy,
  output logic           done,
  output logic [dw-1:0]  OUT,
  output logic [dw-1:0]  HI,
  output logic           CO,
  output logic           V,
  output logic           Z,
  output logic           N
);

  localparam int unsigned CW  = SHW + 1;
  localparam int unsigned DW1 = dw + 1;
  localparam logic [CW-1:0] LAST = CW'(dw - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [dw-1:0] opb_q, opb_d;   // latched multiplicand or divisor
  logic [dw-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [dw-1:0] lo_q, lo_d;     // multiplier -> product low / dividend -> quotient
  logic [dw-1:0] out_q, out_d;
  logic [dw-1:0] hi_q, hi_d;
  logic          co_q, co_d, v_q, v_d, z_q, z_d, n_q, n_d;
  logic          done_q, done_d, busy_q, busy_d;

  // Classic 6502 add/sub/logic datapath
  logic [dw-1:0] alu_tb, alu_out;
  logic [dw:0]   alu_sum;
  logic          alu_co, alu_v;

  always_comb begin
    alu_tb  = BI;
    alu_out = AI;
    alu_co  = 1'b0;
    alu_v   = 1'b0;
    case (op)
      4'b0111: alu_tb = ~BI;
      4'b1011: alu_tb = AI;
      default: alu_tb = BI;
    endcase
    alu_sum = {1'b0, AI} + {1'b0, alu_tb} + DW1'(CI);
    case (op)
      4'b0011, 4'b0111, 4'b1011: begin
        alu_out = alu_sum[dw-1:0];
        alu_co  = alu_sum[dw];
        alu_v   = (AI[dw-1] == alu_tb[dw-1]) && (alu_sum[dw-1] != AI[dw-1]);
      end
      4'b1100: alu_out = AI | BI;
      4'b1101: alu_out = AI & BI;
      4'b1110: alu_out = AI ^ BI;
      default: alu_out = AI;
    endcase
  end

  // Barrel shifter; extra bit on each shift captures the last bit shifted out
  logic [dw:0]   shl_ext, shr_ext;
  logic [CW-1:0] inv_amt;
  logic [dw-1:0] rotl, rotr, sh_out;
  logic          sh_co;

  always_comb begin
    shl_ext = {1'b0, AI} << EI;
    shr_ext = $signed({AI, 1'b0}) >>> EI;
    inv_amt = CW'(dw) - CW'(EI);
    rotl    = (AI << EI) | (AI >> inv_amt);
    rotr    = (AI >> EI) | (AI << inv_amt);
    sh_out  = AI;
    sh_co   = CI;
    if (EI != '0) begin
      case ({right, rotate})
        2'b00:   begin sh_out = shl_ext[dw-1:0]; sh_co = shl_ext[dw]; end
        2'b01:   begin sh_out = rotl;            sh_co = rotl[0];     end
        2'b10:   begin sh_out = shr_ext[dw:1];   sh_co = shr_ext[0];  end
        default: begin sh_out = rotr;            sh_co = rotr[dw-1];  end
      endcase
    end
  end

  // One shift-add multiply step and one restoring-divide step
  logic [dw:0]   mul_sum, div_shift, div_trial;
  logic [dw-1:0] mul_acc_nx, mul_lo_nx, div_acc_nx, div_lo_nx;

  always_comb begin
    mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_acc_nx = mul_sum[dw:1];
    mul_lo_nx  = {mul_sum[0], lo_q[dw-1:1]};
    div_shift  = {acc_q, lo_q[dw-1]};
    div_trial  = div_shift - {1'b0, opb_q};
    if (!div_trial[dw]) begin
      div_acc_nx = div_trial[dw-1:0];
      div_lo_nx  = {lo_q[dw-2:0], 1'b1};
    end else begin
      div_acc_nx = div_shift[dw-1:0];
      div_lo_nx  = {lo_q[dw-2:0], 1'b0};
    end
  end

  // Sequencer next-state and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    out_d   = out_q;
    hi_d    = hi_q;
    co_d    = co_q;
    v_d     = v_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (mode)
            2'b00: begin
              out_d  = alu_out;
              hi_d   = '0;
              co_d   = alu_co;
              v_d    = alu_v;
              done_d = 1'b1;
            end
            2'b01: begin
              out_d  = sh_out;
              hi_d   = '0;
              co_d   = sh_co;
              v_d    = 1'b0;
              done_d = 1'b1;
            end
            2'b10: begin
              state_d = S_MUL;
              cnt_d   = '0;
              opb_d   = AI;
              acc_d   = '0;
              lo_d    = BI;
            end
            default: begin
              state_d = S_DIV;
              cnt_d   = '0;
              opb_d   = BI;
              acc_d   = '0;
              lo_d    = AI;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_acc_nx;
        lo_d  = mul_lo_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          out_d   = mul_lo_nx;
          hi_d    = mul_acc_nx;
          co_d    = |mul_acc_nx;
          v_d     = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DIV: begin
        acc_d = div_acc_nx;
        lo_d  = div_lo_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          out_d   = div_lo_nx;
          hi_d    = div_acc_nx;
          co_d    = 1'b0;
          v_d     = (opb_q == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    z_d    = done_d ? (out_d == '0) : z_q;
    n_d    = done_d ? out_d[dw-1] : n_q;
    busy_d = (state_d != S_IDLE);
  end

  // State register; RDY low freezes everything, reset overrides RDY
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (RDY) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      co_q    <= co_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign OUT  = out_q;
  assign HI   = hi_q;
  assign CO   = co_q;
  assign V    = v_q;
  assign Z    = z_q;
  assign N    = n_q;

endmodule
